// File: rtl/fpr_wb_arbiter_pkg.sv
// Shared FP writeback types: data/address words, IEEE flag bundle,
// writeback source encoding and the registered write-port record.
package fpr_wb_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_FPRS = 32;
    localparam int FPR_AW   = $clog2(NUM_FPRS);

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [FPR_AW-1:0] fpr_addr_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_FPU  = 2'd1,
        WB_LSU  = 2'd2,
        WB_DIV  = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic      we;
        fpr_addr_t addr;
        word_t     data;
        wb_src_e   src;
        logic      fflags_we;
        fflags_t   fflags;
    } wb_req_t;

endpackage

// File: rtl/fpr_wb_arbiter_if.sv
// Producer-side and FPR-write-side signals of the FP writeback arbiter.
// master = producers/consumers around the arbiter, slave = the arbiter.
interface fpr_wb_arbiter_if;
    import fpr_wb_arbiter_pkg::*;

    logic      fpu_valid;
    fpr_addr_t fpu_rd;
    word_t     fpu_data;
    fflags_t   fpu_fflags;

    logic      lsu_valid;
    logic      lsu_ready;
    fpr_addr_t lsu_rd;
    word_t     lsu_data;

    logic      div_valid;
    logic      div_ready;
    fpr_addr_t div_rd;
    word_t     div_data;
    fflags_t   div_fflags;

    logic      fpr_we;
    fpr_addr_t fpr_waddr;
    word_t     fpr_wdata;
    wb_src_e   wb_src;
    logic      fflags_we;
    fflags_t   fflags_acc;

    modport slave (
        input  fpu_valid, fpu_rd, fpu_data, fpu_fflags,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        input  div_valid, div_rd, div_data, div_fflags,
        output div_ready,
        output fpr_we, fpr_waddr, fpr_wdata,
        output wb_src, fflags_we, fflags_acc
    );

    modport master (
        output fpu_valid, fpu_rd, fpu_data, fpu_fflags,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        output div_valid, div_rd, div_data, div_fflags,
        input  div_ready,
        input  fpr_we, fpr_waddr, fpr_wdata,
        input  wb_src, fflags_we, fflags_acc
    );

endinterface

// File: rtl/fpr_wb_starve_ctr.sv
// Saturating refusal counter; starved goes high once a requester has
// been refused LIMIT times in a row without being granted.
module fpr_wb_starve_ctr #(
    parameter int LIMIT = 8,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic grant,
    output logic starved
);

    logic [CNT_W-1:0] cnt;

    assign starved = (cnt == CNT_W'(LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (req && grant) begin
            cnt <= '0;
        end else if (req && !starved) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fpr_wb_arbiter.sv
// FP register-file writeback arbiter: FPU > LSU > DIV, with DIV
// promoted above LSU once it has been starved; one-cycle registered write.
module fpr_wb_arbiter
    import fpr_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input logic             clk,
    input logic             rst,
    fpr_wb_arbiter_if.slave bus
);

    logic    starved;
    logic    pick_fpu;
    logic    pick_lsu;
    logic    pick_div;
    wb_src_e sel;
    wb_req_t cur;
    wb_req_t nxt;

    fpr_wb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.div_valid),
        .grant   (bus.div_ready),
        .starved (starved)
    );

    // Mutually exclusive picks so the decoder below stays one-hot.
    always_comb begin
        pick_fpu = bus.fpu_valid;
        pick_lsu = !bus.fpu_valid && bus.lsu_valid
                 && !(starved && bus.div_valid);
        pick_div = !bus.fpu_valid && bus.div_valid
                 && (starved || !bus.lsu_valid);
    end

    always_comb begin
        sel = WB_NONE;
        unique case (1'b1)
            pick_fpu: sel = WB_FPU;
            pick_lsu: sel = WB_LSU;
            pick_div: sel = WB_DIV;
            default:  sel = WB_NONE;
        endcase
    end

    assign bus.lsu_ready = !rst && (sel == WB_LSU);
    assign bus.div_ready = !rst && (sel == WB_DIV);

    always_comb begin
        nxt           = cur;
        nxt.we        = 1'b0;
        nxt.src       = WB_NONE;
        nxt.fflags_we = 1'b0;
        nxt.fflags    = '0;
        unique case (sel)
            WB_FPU: begin
                nxt.we        = 1'b1;
                nxt.addr      = bus.fpu_rd;
                nxt.data      = bus.fpu_data;
                nxt.src       = WB_FPU;
                nxt.fflags_we = 1'b1;
                nxt.fflags    = bus.fpu_fflags;
            end
            WB_LSU: begin
                nxt.we   = 1'b1;
                nxt.addr = bus.lsu_rd;
                nxt.data = bus.lsu_data;
                nxt.src  = WB_LSU;
            end
            WB_DIV: begin
                nxt.we        = 1'b1;
                nxt.addr      = bus.div_rd;
                nxt.data      = bus.div_data;
                nxt.src       = WB_DIV;
                nxt.fflags_we = 1'b1;
                nxt.fflags    = bus.div_fflags;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    assign bus.fpr_we     = cur.we;
    assign bus.fpr_waddr  = cur.addr;
    assign bus.fpr_wdata  = cur.data;
    assign bus.wb_src     = cur.src;
    assign bus.fflags_we  = cur.fflags_we;
    assign bus.fflags_acc = cur.fflags;

endmodule

// File: tb/tb_fpr_wb_arbiter.sv
// Directed bench for fpr_wb_arbiter: vector table for single-cycle
// arbitration plus sequences for reset, starvation and saturation.
module tb_fpr_wb_arbiter;
    import fpr_wb_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    fpr_wb_arbiter_if bus ();

    fpr_wb_arbiter #(
        .STARVE_LIMIT (8),
        .CNT_W        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fd;
        logic [4:0]  ff;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        dv;
        logic [4:0]  drd;
        logic [31:0] dd;
        logic [4:0]  df;
        logic        e_lr;
        logic        e_dr;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [1:0]  e_src;
        logic        e_fwe;
        logic [4:0]  e_acc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.fpu_valid  = v.fv;
        bus.fpu_rd     = v.frd;
        bus.fpu_data   = v.fd;
        bus.fpu_fflags = v.ff;
        bus.lsu_valid  = v.lv;
        bus.lsu_rd     = v.lrd;
        bus.lsu_data   = v.ld;
        bus.div_valid  = v.dv;
        bus.div_rd     = v.drd;
        bus.div_data   = v.dd;
        bus.div_fflags = v.df;
    endtask

    task automatic idle_inputs();
        bus.fpu_valid  = 1'b0;
        bus.fpu_rd     = '0;
        bus.fpu_data   = '0;
        bus.fpu_fflags = '0;
        bus.lsu_valid  = 1'b0;
        bus.lsu_rd     = '0;
        bus.lsu_data   = '0;
        bus.div_valid  = 1'b0;
        bus.div_rd     = '0;
        bus.div_data   = '0;
        bus.div_fflags = '0;
    endtask

    function automatic logic [31:0] cnt_now();
        return 32'(dut.u_starve.cnt);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();

        //       fv frd  fd            ff     lv lrd  ld
        //       dv drd  dd            df     lr dr we a d src fwe acc
        vecs[0] = '{1, 3, 32'h3F800000, 5'h01,
                    0, 0, 32'h0,
                    0, 0, 32'h0, 5'h00,
                    0, 0, 1, 3, 32'h3F800000, 1, 1, 5'h01};
        vecs[1] = '{0, 0, 32'h0, 5'h00,
                    1, 7, 32'hDEADBEEF,
                    0, 0, 32'h0, 5'h00,
                    1, 0, 1, 7, 32'hDEADBEEF, 2, 0, 5'h00};
        vecs[2] = '{1, 1, 32'h40000000, 5'h10,
                    1, 2, 32'h11111111,
                    1, 4, 32'h22222222, 5'h08,
                    0, 0, 1, 1, 32'h40000000, 1, 1, 5'h10};
        vecs[3] = '{0, 0, 32'h0, 5'h00,
                    1, 2, 32'h11111111,
                    1, 4, 32'h22222222, 5'h08,
                    1, 0, 1, 2, 32'h11111111, 2, 0, 5'h00};
        vecs[4] = '{0, 0, 32'h0, 5'h00,
                    0, 0, 32'h0,
                    1, 4, 32'h22222222, 5'h08,
                    0, 1, 1, 4, 32'h22222222, 3, 1, 5'h08};
        vecs[5] = '{0, 0, 32'h0, 5'h00,
                    0, 0, 32'h0,
                    0, 0, 32'h0, 5'h00,
                    0, 0, 0, 4, 32'h22222222, 0, 0, 5'h00};
        vecs[6] = '{0, 0, 32'h0, 5'h00,
                    0, 0, 32'h0,
                    1, 0, 32'h3F000000, 5'h1F,
                    0, 1, 1, 0, 32'h3F000000, 3, 1, 5'h1F};
        vecs[7] = '{1, 5, 32'hAAAA0000, 5'h00,
                    1, 5, 32'hBBBB0000,
                    0, 0, 32'h0, 5'h00,
                    0, 0, 1, 5, 32'hAAAA0000, 1, 1, 5'h00};
        vecs[8] = '{0, 0, 32'h0, 5'h00,
                    1, 5, 32'hBBBB0000,
                    0, 0, 32'h0, 5'h00,
                    1, 0, 1, 5, 32'hBBBB0000, 2, 0, 5'h00};
        vecs[9] = '{0, 0, 32'h0, 5'h00,
                    0, 0, 32'h0,
                    0, 0, 32'h0, 5'h00,
                    0, 0, 0, 5, 32'hBBBB0000, 0, 0, 5'h00};

        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(bus.fpr_we), 0);
        check("rst_src", 32'(bus.wb_src), 0);
        check("rst_waddr", 32'(bus.fpr_waddr), 0);
        check("rst_wdata", bus.fpr_wdata, 0);
        check("rst_cnt", cnt_now(), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_lsu_ready", i),
                  32'(bus.lsu_ready), 32'(vecs[i].e_lr));
            check($sformatf("v%0d_div_ready", i),
                  32'(bus.div_ready), 32'(vecs[i].e_dr));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_we", i),
                  32'(bus.fpr_we), 32'(vecs[i].e_we));
            check($sformatf("v%0d_waddr", i),
                  32'(bus.fpr_waddr), 32'(vecs[i].e_a));
            check($sformatf("v%0d_wdata", i),
                  bus.fpr_wdata, vecs[i].e_d);
            check($sformatf("v%0d_src", i),
                  32'(bus.wb_src), 32'(vecs[i].e_src));
            check($sformatf("v%0d_fflags_we", i),
                  32'(bus.fflags_we), 32'(vecs[i].e_fwe));
            if (vecs[i].e_we)
                check($sformatf("v%0d_fflags_acc", i),
                      32'(bus.fflags_acc), 32'(vecs[i].e_acc));
            @(negedge clk);
        end

        // Charge the counter, write via fpu, then reset mid-cycle.
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd9;
        bus.lsu_data  = 32'h12345678;
        bus.div_valid = 1'b1;
        bus.div_rd    = 5'd10;
        bus.div_data  = 32'h87654321;
        bus.div_fflags = 5'h02;
        repeat (3) @(negedge clk);
        bus.fpu_valid = 1'b1;
        bus.fpu_rd    = 5'd11;
        bus.fpu_data  = 32'hCAFEF00D;
        bus.fpu_fflags = 5'h04;
        @(posedge clk);
        #1;
        check("pre_rst_we", 32'(bus.fpr_we), 1);
        check("pre_rst_cnt", cnt_now(), 4);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(bus.fpr_we), 0);
        check("mid_rst_waddr", 32'(bus.fpr_waddr), 0);
        check("mid_rst_wdata", bus.fpr_wdata, 0);
        check("mid_rst_src", 32'(bus.wb_src), 0);
        check("mid_rst_fwe", 32'(bus.fflags_we), 0);
        check("mid_rst_acc", 32'(bus.fflags_acc), 0);
        check("mid_rst_lsu_ready", 32'(bus.lsu_ready), 0);
        check("mid_rst_div_ready", 32'(bus.div_ready), 0);
        check("mid_rst_cnt", cnt_now(), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.fpu_valid = 1'b0;

        // lsu and div both held: 8 lsu wins, then div, then lsu.
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("starve%0d_lsu_ready", i),
                  32'(bus.lsu_ready), 1);
            check($sformatf("starve%0d_div_ready", i),
                  32'(bus.div_ready), 0);
            @(posedge clk);
            #1;
            check($sformatf("starve%0d_src", i),
                  32'(bus.wb_src), 2);
            @(negedge clk);
        end
        #1;
        check("starved_div_ready", 32'(bus.div_ready), 1);
        check("starved_lsu_ready", 32'(bus.lsu_ready), 0);
        @(posedge clk);
        #1;
        check("starved_src", 32'(bus.wb_src), 3);
        check("starved_waddr", 32'(bus.fpr_waddr), 10);
        check("starved_wdata", bus.fpr_wdata, 32'h87654321);
        check("starved_acc", 32'(bus.fflags_acc), 32'h02);
        check("starved_cnt_clr", cnt_now(), 0);
        @(negedge clk);
        #1;
        check("after_lsu_ready", 32'(bus.lsu_ready), 1);
        check("after_div_ready", 32'(bus.div_ready), 0);
        @(posedge clk);
        #1;
        check("after_src", 32'(bus.wb_src), 2);
        check("after_cnt", cnt_now(), 1);
        @(negedge clk);

        // Saturate, then let fpu hog the port for several cycles.
        repeat (7) @(negedge clk);
        check("sat_cnt", cnt_now(), 8);
        bus.fpu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("hog%0d_div_ready", i),
                  32'(bus.div_ready), 0);
            check($sformatf("hog%0d_lsu_ready", i),
                  32'(bus.lsu_ready), 0);
            @(posedge clk);
            #1;
            check($sformatf("hog%0d_src", i), 32'(bus.wb_src), 1);
            check($sformatf("hog%0d_cnt", i), cnt_now(), 8);
            @(negedge clk);
        end
        bus.fpu_valid = 1'b0;
        #1;
        check("release_div_ready", 32'(bus.div_ready), 1);
        check("release_lsu_ready", 32'(bus.lsu_ready), 0);
        @(posedge clk);
        #1;
        check("release_src", 32'(bus.wb_src), 3);
        check("release_cnt", cnt_now(), 0);
        @(negedge clk);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpr_wb_arbiter.md
Name: fpr_wb_arbiter

Overview:
- Writeback stage directly upstream of the floating-point register file write port.
- Merges FP results from three producers into the single FPR write port:
  - the fixed-latency FPU pipe (cannot stall);
  - the LSU FP-load return;
  - the iterative FDIV/FSQRT unit.
- Registers the winning result for one cycle, then drives fpr_we/fpr_waddr/fpr_wdata.
- Accumulates IEEE exception flags for the CSR unit.
- Contains an anti-starvation counter so the divider is never locked out by load traffic.

Parameters:
- STARVE_LIMIT, 8, cycles div_valid may be refused before div gets priority over lsu (1..255).
- CNT_W, 8, width of the starvation counter; must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fpu_valid  in  1  FPU pipe result valid; no ready, always accepted
- fpu_rd  in  fpr_addr_t  destination FPR
- fpu_data  in  word_t  result
- fpu_fflags  in  5  NV,DZ,OF,UF,NX
- lsu_valid  in  1  FP load data valid
- lsu_ready  out  1  load accepted this cycle
- lsu_rd  in  fpr_addr_t  destination
- lsu_data  in  word_t  load data
- div_valid  in  1  divider result valid
- div_ready  out  1  divider result accepted this cycle
- div_rd  in  fpr_addr_t  destination
- div_data  in  word_t  result
- div_fflags  in  5  flags
- fpr_we  out  1  write enable to FPR file
- fpr_waddr  out  fpr_addr_t  write address
- fpr_wdata  out  word_t  write data
- wb_src  out  2  source of current write: 0 none, 1 fpu, 2 lsu, 3 div
- fflags_we  out  1  fflags_acc valid, OR into fcsr.fflags
- fflags_acc  out  5  flags of the current write

Behaviour:
- Reset (async, rst=1): fpr_we=0, fpr_waddr=0, fpr_wdata=0, wb_src=0, fflags_we=0, fflags_acc=0, starvation counter=0. lsu_ready/div_ready are combinational and evaluate to 0 while rst=1.
- Selection is combinational each cycle; the winner's fields are registered. Latency is exactly 1 cycle from accept to fpr_we=1.
- Priority, normal mode (counter < STARVE_LIMIT): fpu > lsu > div.
- Priority, starved mode (counter == STARVE_LIMIT): fpu > div > lsu.
- Handshakes:
  - lsu_ready=1 iff lsu is the selected winner; likewise div_ready for div.
  - Ready is independent of the source's own valid except through selection: a source with valid=0 is never selected, so its ready is 0.
  - fpu always wins when fpu_valid=1; lsu_ready=div_ready=0 in that cycle.
- Starvation counter:
  - +1 per cycle with div_valid=1 and div_ready=0, saturating at STARVE_LIMIT.
  - Clears to 0 on any cycle with div_valid && div_ready.
  - Holds when div_valid=0.
- Output register when a winner exists: fpr_we=1, fpr_waddr/fpr_wdata from winner, wb_src set.
  - fflags_we=1 for fpu/div with fflags_acc = winner flags.
  - For lsu: fflags_we=0, fflags_acc=0.
- No winner: fpr_we=0, fflags_we=0, wb_src=0. fpr_waddr/fpr_wdata hold their previous values.
- Destination f0 is a normal register (FP file has no zero register) and is written like any other.
- Same rd from two sources in one cycle: only the winner writes; the loser retries next cycle. Ordering between producers is guaranteed by the upstream scoreboard, not here.
- Reset asserted mid-handshake: the pending write is dropped, the counter clears, and the write port deasserts immediately (asynchronous).

Decomposition:
- Shared bitutils package (word_t, fpr_addr_t, NUM_FPRS already there) gains:
  - fflags_t (5-bit packed: nv,dz,of,uf,nx);
  - wb_src_e enum (WB_NONE, WB_FPU, WB_LSU, WB_DIV).
- One natural sub-module: fpr_wb_starve_ctr (saturating counter plus starved flag), reusable by other writeback arbiters.

Test Plan:
- Reset: rst=1 mid-run -> all outputs 0 same cycle, counter 0.
- Single sources:
  - fpu_valid=1, rd=3, data=0x3F800000, fflags=0x01 -> next cycle fpr_we=1, waddr=3, wdata=0x3F800000, wb_src=1, fflags_we=1, fflags_acc=0x01.
  - lsu-only valid, rd=7, data=0xDEADBEEF -> lsu_ready=1 same cycle; next cycle write to f7, wb_src=2, fflags_we=0.
- Simultaneous fpu+lsu+div -> fpu wins, lsu_ready=div_ready=0. Next cycle with fpu idle -> lsu wins, div still refused.
- Starvation, STARVE_LIMIT=8: hold lsu_valid and div_valid=1 continuously -> lsu wins 8 cycles. On the 9th cycle div_ready=1 and div writes. Counter then returns to 0 and lsu wins again.
- fpu_valid=1 every cycle with div waiting and counter saturated -> div still refused, counter stays 8. After fpu drops, div is accepted first, ahead of lsu.
